// File: rtl/fifo_sync_flow.sv
// Synchronous FIFO: arbitrary depth, optional fall-through, thresholds, flush.
// Define FIFO_SYNC_FLOW_ERR_EN to add err_clr and sticky overflow/underflow.
module fifo_sync_flow #(
    parameter int DATA_WIDTH   = 32,
    parameter int DEPTH        = 8,
    parameter int FALL_THROUGH = 1,
    parameter int CNT_W        = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  flush,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  full,
    output logic                  empty,
    input  logic [CNT_W-1:0]      afull_thr,
    input  logic [CNT_W-1:0]      aempty_thr,
    output logic                  afull,
    output logic                  aempty,
    output logic [CNT_W-1:0]      count
`ifdef FIFO_SYNC_FLOW_ERR_EN
    ,
    input  logic                  err_clr,
    output logic                  overflow,
    output logic                  underflow
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
    localparam bit FT = (FALL_THROUGH != 0);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;

    logic bypass;
    logic push_acc;
    logic pop_acc;
    logic wr_en;
    logic rd_en;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    assign empty  = (count_q == '0);
    assign full   = (count_q == CNT_FULL);
    assign afull  = (count_q >= afull_thr);
    assign aempty = (count_q <= aempty_thr);
    assign count  = count_q;

    assign bypass   = FT && empty && push;
    assign pop_acc  = pop && (!empty || bypass);
    assign push_acc = push && (!full || pop);

    // A bypassed word goes straight from din to the consumer, never stored.
    assign wr_en = push_acc && !(bypass && pop) && !flush;
    assign rd_en = pop_acc && !(bypass && pop) && !flush;

    assign dout = bypass ? din : mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (wr_en) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (rd_en) rd_ptr_d = ptr_inc(rd_ptr_q);
            count_d = count_q + CNT_W'(wr_en) - CNT_W'(rd_en);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (wr_en) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

`ifdef FIFO_SYNC_FLOW_ERR_EN
    logic ovf_q;
    logic unf_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            ovf_q <= (push && !push_acc && !flush) || (ovf_q && !err_clr);
            unf_q <= (pop && !pop_acc && !flush) || (unf_q && !err_clr);
        end
    end

    assign overflow  = ovf_q;
    assign underflow = unf_q;
`endif

endmodule

// File: tb/tb_fifo_sync_flow.sv
// Bench for fifo_sync_flow: DEPTH=5 registered and DEPTH=8 fall-through
// instances, directed scenarios plus random traffic against queue models.
module tb_fifo_sync_flow;

    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          flush = 1'b0;
    logic          push = 1'b0;
    logic          pop = 1'b0;
    logic          err_clr = 1'b0;
    logic [DW-1:0] din = '0;
    logic [2:0]    aft5 = 3'd4, aet5 = 3'd1;
    logic [3:0]    aft8 = 4'd4, aet8 = 4'd1;

    logic [DW-1:0] dout5, dout8;
    logic          full5, empty5, afull5, aempty5;
    logic          full8, empty8, afull8, aempty8;
    logic [2:0]    count5;
    logic [3:0]    count8;
`ifdef FIFO_SYNC_FLOW_ERR_EN
    logic          ovf5, unf5, ovf8, unf8;
`endif

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] q5[$];
    logic [DW-1:0] q8[$];
    bit mo5, mu5, mo8, mu8;

    always #5 clk = ~clk;

    fifo_sync_flow #(.DATA_WIDTH(DW), .DEPTH(5), .FALL_THROUGH(0)) u5 (
        .clk(clk), .reset_n(reset_n), .flush(flush), .push(push),
        .din(din), .pop(pop), .dout(dout5), .full(full5), .empty(empty5),
        .afull_thr(aft5), .aempty_thr(aet5), .afull(afull5),
        .aempty(aempty5), .count(count5)
`ifdef FIFO_SYNC_FLOW_ERR_EN
        , .err_clr(err_clr), .overflow(ovf5), .underflow(unf5)
`endif
    );

    fifo_sync_flow #(.DATA_WIDTH(DW), .DEPTH(8), .FALL_THROUGH(1)) u8 (
        .clk(clk), .reset_n(reset_n), .flush(flush), .push(push),
        .din(din), .pop(pop), .dout(dout8), .full(full8), .empty(empty8),
        .afull_thr(aft8), .aempty_thr(aet8), .afull(afull8),
        .aempty(aempty8), .count(count8)
`ifdef FIFO_SYNC_FLOW_ERR_EN
        , .err_clr(err_clr), .overflow(ovf8), .underflow(unf8)
`endif
    );

    task automatic mstep(ref logic [DW-1:0] q[$], input int depth,
                         input bit ft, ref bit mo, ref bit mu);
        bit pok, wok, so, su;
        so = 0;
        su = 0;
        if (!flush) begin
            if (!(ft && q.size() == 0 && push && pop)) begin
                pok = pop && q.size() != 0;
                wok = push && (q.size() < depth || pop);
                so = push && !wok;
                su = pop && !pok;
                if (pok) void'(q.pop_front());
                if (wok) q.push_back(din);
            end
        end else begin
            q.delete();
        end
        mo = so || (mo && !err_clr);
        mu = su || (mu && !err_clr);
    endtask

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q5.delete();
            q8.delete();
            mo5 = 0; mu5 = 0; mo8 = 0; mu8 = 0;
        end else begin
            mstep(q5, 5, 1'b0, mo5, mu5);
            mstep(q8, 8, 1'b1, mo8, mu8);
        end
    end

    task automatic drive(input bit p, input bit o, input logic [DW-1:0] d,
                         input bit f);
        push = p;
        pop = o;
        din = d;
        flush = f;
    endtask

    task automatic do_flush();
        drive(0, 0, '0, 1);
        @(negedge clk);
        drive(0, 0, '0, 0);
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if (count5 !== 3'd0 || empty5 !== 1'b1 || full5 !== 1'b0) begin
            errors++;
            $display("FAIL reset5 cnt=%0d e=%b f=%b exp 0 1 0", count5, empty5, full5);
        end
        checks++;
        if (dout5 !== 8'h00 || dout8 !== 8'h00) begin
            errors++;
            $display("FAIL reset_dout got %h/%h exp 00", dout5, dout8);
        end
        checks++;
        if (afull8 !== 1'b0 || aempty8 !== 1'b1 || count8 !== 4'd0) begin
            errors++;
            $display("FAIL reset_thr8 af=%b ae=%b cnt=%0d exp 0 1 0", afull8, aempty8, count8);
        end
`ifdef FIFO_SYNC_FLOW_ERR_EN
        checks++;
        if (ovf5 !== 1'b0 || unf5 !== 1'b0) begin
            errors++;
            $display("FAIL reset_err got %b%b exp 00", ovf5, unf5);
        end
`endif
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_overflow();
        do_flush();
        for (int v = 1; v <= 7; v++) begin
            drive(1, 0, DW'(v), 0);
            @(negedge clk);
        end
        drive(0, 0, '0, 0);
        checks++;
        if (count5 !== 3'd5 || full5 !== 1'b1) begin
            errors++;
            $display("FAIL ovf_full cnt=%0d f=%b exp 5 1", count5, full5);
        end
`ifdef FIFO_SYNC_FLOW_ERR_EN
        checks++;
        if (ovf5 !== 1'b1) begin
            errors++;
            $display("FAIL ovf_flag got %b exp 1", ovf5);
        end
`endif
        for (int i = 1; i <= 5; i++) begin
            drive(0, 1, '0, 0);
            #1;
            checks++;
            if (dout5 !== DW'(i)) begin
                errors++;
                $display("FAIL ovf_drain got %0d exp %0d", dout5, i);
            end
            @(negedge clk);
        end
        drive(0, 0, '0, 0);
        checks++;
        if (empty5 !== 1'b1) begin
            errors++;
            $display("FAIL ovf_empty got %b exp 1", empty5);
        end
    endtask

    task automatic test_wrap();
        int n;
        do_flush();
        for (int r = 0; r < 2; r++) begin
            n = (r == 0) ? 3 : 5;
            for (int i = 0; i < n; i++) begin
                drive(1, 0, DW'(8'h20 + 16 * r + i), 0);
                @(negedge clk);
            end
            for (int i = 0; i < n; i++) begin
                drive(0, 1, '0, 0);
                #1;
                checks++;
                if (dout5 !== DW'(8'h20 + 16 * r + i)) begin
                    errors++;
                    $display("FAIL wrap_data got %h exp %h", dout5, 8'h20 + 16 * r + i);
                end
                @(negedge clk);
            end
        end
        drive(0, 0, '0, 0);
        checks++;
        if (count5 !== 3'd0) begin
            errors++;
            $display("FAIL wrap_count got %0d exp 0", count5);
        end
    endtask

    task automatic test_full_pop();
        logic [DW-1:0] exp_seq[5] = '{8'd11, 8'd12, 8'd13, 8'd14, 8'd99};
        do_flush();
        for (int i = 10; i <= 14; i++) begin
            drive(1, 0, DW'(i), 0);
            @(negedge clk);
        end
        drive(1, 1, 8'd99, 0);
        #1;
        checks++;
        if (dout5 !== 8'd10 || full5 !== 1'b1) begin
            errors++;
            $display("FAIL fp_head got %0d f=%b exp 10 1", dout5, full5);
        end
        @(negedge clk);
        drive(0, 0, '0, 0);
        checks++;
        if (count5 !== 3'd5) begin
            errors++;
            $display("FAIL fp_count got %0d exp 5", count5);
        end
        for (int i = 0; i < 5; i++) begin
            drive(0, 1, '0, 0);
            #1;
            checks++;
            if (dout5 !== exp_seq[i]) begin
                errors++;
                $display("FAIL fp_drain got %0d exp %0d", dout5, exp_seq[i]);
            end
            @(negedge clk);
        end
        drive(0, 0, '0, 0);
    endtask

    task automatic test_bypass();
        do_flush();
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        drive(1, 1, 8'hA5, 0);
        #1;
        checks++;
        if (dout8 !== 8'hA5) begin
            errors++;
            $display("FAIL byp_dout got %h exp a5", dout8);
        end
        @(negedge clk);
        drive(0, 0, '0, 0);
        checks++;
        if (count8 !== 4'd0 || count5 !== 3'd1) begin
            errors++;
            $display("FAIL byp_count got %0d/%0d exp 0/1", count8, count5);
        end
        checks++;
        if (dout5 !== 8'hA5) begin
            errors++;
            $display("FAIL byp_ft0_dout got %h exp a5", dout5);
        end
`ifdef FIFO_SYNC_FLOW_ERR_EN
        checks++;
        if (unf8 !== 1'b0 || unf5 !== 1'b1) begin
            errors++;
            $display("FAIL byp_unf got %b/%b exp 0/1", unf8, unf5);
        end
`endif
    endtask

    task automatic test_thresholds();
        do_flush();
        aft8 = 4'd4;
        aet8 = 4'd1;
        for (int k = 1; k <= 4; k++) begin
            drive(1, 0, DW'(k), 0);
            @(negedge clk);
            drive(0, 0, '0, 0);
            checks++;
            if (afull8 !== (k >= 4) || aempty8 !== (k <= 1)) begin
                errors++;
                $display("FAIL thr_k%0d af=%b ae=%b exp %b %b", k, afull8, aempty8, k >= 4, k <= 1);
            end
        end
        do_flush();
        checks++;
        if (count8 !== 4'd0 || aempty8 !== 1'b1 || afull8 !== 1'b0) begin
            errors++;
            $display("FAIL thr_flush cnt=%0d ae=%b af=%b exp 0 1 0", count8, aempty8, afull8);
        end
`ifdef FIFO_SYNC_FLOW_ERR_EN
        checks++;
        if (unf5 !== 1'b1) begin
            errors++;
            $display("FAIL flush_keeps_err got %b exp 1", unf5);
        end
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        checks++;
        if (unf5 !== 1'b0 || ovf5 !== 1'b0) begin
            errors++;
            $display("FAIL err_clr got %b%b exp 00", ovf5, unf5);
        end
`endif
        aft8 = 4'd0;
        aet8 = 4'd9;
        #1;
        checks++;
        if (afull8 !== 1'b1 || aempty8 !== 1'b1) begin
            errors++;
            $display("FAIL thr_const af=%b ae=%b exp 1 1", afull8, aempty8);
        end
    endtask

    task automatic test_random();
        logic [DW-1:0] e5, e8;
        for (int c = 0; c < 600; c++) begin
            drive($urandom_range(0, 99) < 60, $urandom_range(0, 99) < 45,
                  DW'($urandom), $urandom_range(0, 31) == 0);
            err_clr = ($urandom_range(0, 15) == 0);
            aft5 = 3'($urandom);
            aet5 = 3'($urandom);
            aft8 = 4'($urandom);
            aet8 = 4'($urandom);
            #1;
            checks++;
            if (count5 !== 3'(q5.size()) || full5 !== (q5.size() == 5) ||
                empty5 !== (q5.size() == 0) || afull5 !== (q5.size() >= aft5) ||
                aempty5 !== (q5.size() <= aet5)) begin
                errors++;
                $display("FAIL rnd5_state c=%0d cnt=%0d exp %0d", c, count5, q5.size());
            end
            checks++;
            if (count8 !== 4'(q8.size()) || full8 !== (q8.size() == 8) ||
                empty8 !== (q8.size() == 0) || afull8 !== (q8.size() >= aft8) ||
                aempty8 !== (q8.size() <= aet8)) begin
                errors++;
                $display("FAIL rnd8_state c=%0d cnt=%0d exp %0d", c, count8, q8.size());
            end
            if (q5.size() != 0) begin
                e5 = q5[0];
                checks++;
                if (dout5 !== e5) begin
                    errors++;
                    $display("FAIL rnd5_dout c=%0d got %h exp %h", c, dout5, e5);
                end
            end
            if (q8.size() != 0 || push) begin
                e8 = (q8.size() != 0) ? q8[0] : din;
                checks++;
                if (dout8 !== e8) begin
                    errors++;
                    $display("FAIL rnd8_dout c=%0d got %h exp %h", c, dout8, e8);
                end
            end
`ifdef FIFO_SYNC_FLOW_ERR_EN
            checks++;
            if (ovf5 !== mo5 || unf5 !== mu5 || ovf8 !== mo8 || unf8 !== mu8) begin
                errors++;
                $display("FAIL rnd_err c=%0d got %b%b%b%b exp %b%b%b%b", c,
                         ovf5, unf5, ovf8, unf8, mo5, mu5, mo8, mu8);
            end
`endif
            @(negedge clk);
        end
        drive(0, 0, '0, 0);
        err_clr = 1'b0;
    endtask

    task automatic test_async_reset();
        aft5 = 3'd4; aet5 = 3'd1; aft8 = 4'd4; aet8 = 4'd1;
        for (int i = 0; i < 4; i++) begin
            drive(1, 0, DW'($urandom), 0);
            @(negedge clk);
        end
        @(posedge clk);
        #3;
        reset_n = 1'b0;
        drive(0, 0, '0, 0);
        #1;
        checks++;
        if (count5 !== 3'd0 || empty5 !== 1'b1 || dout5 !== 8'h00) begin
            errors++;
            $display("FAIL arst5 cnt=%0d e=%b d=%h exp 0 1 00", count5, empty5, dout5);
        end
        checks++;
        if (count8 !== 4'd0 || empty8 !== 1'b1 || dout8 !== 8'h00) begin
            errors++;
            $display("FAIL arst8 cnt=%0d e=%b d=%h exp 0 1 00", count8, empty8, dout8);
        end
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        drive(1, 0, 8'h3C, 0);
        @(negedge clk);
        drive(0, 0, '0, 0);
        checks++;
        if (dout5 !== 8'h3C || dout8 !== 8'h3C || count5 !== 3'd1) begin
            errors++;
            $display("FAIL arst_after d=%h/%h cnt=%0d exp 3c 1", dout5, dout8, count5);
        end
    endtask

    initial begin
        test_reset();
        test_overflow();
        test_wrap();
        test_full_pop();
        test_bypass();
        test_thresholds();
        test_random();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
